// File: rtl/nor_logic_accum_unit_if.sv
// Operand/result handshake bundle for nor_logic_accum_unit.
// The master drives the operand beat and consumer ready; the slave returns the FIFO head and accumulator.
interface nor_logic_accum_unit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic             clr_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             parity;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] acc_cnt;

  modport master (
    output in_valid, a, b, mode, clr_acc, out_ready,
    input  in_ready, out_valid, y, parity, acc, acc_cnt
  );

  modport slave (
    input  in_valid, a, b, mode, clr_acc, out_ready,
    output in_ready, out_valid, y, parity, acc, acc_cnt
  );
endinterface

// File: rtl/nor_logic_accum_unit.sv
// Bitwise XOR/XNOR/NOR unit with an XOR-folding checksum accumulator.
// Results are tagged with even parity and queued in a DEPTH-entry FIFO.
module nor_logic_accum_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  nor_logic_accum_unit_if.slave io_bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ModeXor  = 2'b00,
    ModeXnor = 2'b01,
    ModeNor  = 2'b10,
    ModeAcc  = 2'b11
  } mode_e;

  logic [WIDTH:0]     r_mem [DEPTH];
  logic [PtrW-1:0]    r_wr_ptr;
  logic [PtrW-1:0]    r_rd_ptr;
  logic [PtrW:0]      r_count;
  logic [WIDTH-1:0]   r_y;
  logic               r_parity;
  logic [WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]   r_acc_cnt;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_acc_beat;
  logic [WIDTH-1:0]   w_acc_base;
  logic [WIDTH-1:0]   w_result;
  logic [WIDTH:0]     w_entry;
  logic [PtrW-1:0]    w_rd_next;

  assign w_full     = (r_count == (PtrW + 1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = io_bus.in_valid & ~rst & ~w_full;
  assign w_pop      = ~w_empty & io_bus.out_ready;
  assign w_acc_beat = w_push & (mode_e'(io_bus.mode) == ModeAcc);
  assign w_rd_next  = r_rd_ptr + PtrW'(1);

  // A clear in the same cycle as an ACC beat drops the old accumulator first.
  assign w_acc_base = io_bus.clr_acc ? '0 : r_acc;

  always_comb begin
    w_result = '0;
    unique case (mode_e'(io_bus.mode))
      ModeXor:  w_result = io_bus.a ^ io_bus.b;
      ModeXnor: w_result = ~(io_bus.a ^ io_bus.b);
      ModeNor:  w_result = ~(io_bus.a | io_bus.b);
      ModeAcc:  w_result = w_acc_base ^ io_bus.a ^ io_bus.b;
    endcase
  end

  assign w_entry = {w_result, ^w_result};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (PtrW + 1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (PtrW + 1)'(1);
      end
    end
  end

  // Head is held in its own register so y/parity stay put once the FIFO drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y      <= '0;
      r_parity <= 1'b0;
    end else if (w_pop) begin
      if (r_count > (PtrW + 1)'(1)) begin
        r_y      <= r_mem[w_rd_next][WIDTH:1];
        r_parity <= r_mem[w_rd_next][0];
      end else if (w_push) begin
        r_y      <= w_entry[WIDTH:1];
        r_parity <= w_entry[0];
      end
    end else if (w_push && w_empty) begin
      r_y      <= w_entry[WIDTH:1];
      r_parity <= w_entry[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_acc_cnt <= '0;
    end else if (w_acc_beat) begin
      r_acc <= w_result;
      if (io_bus.clr_acc) begin
        r_acc_cnt <= CNT_W'(1);
      end else if (r_acc_cnt != '1) begin
        r_acc_cnt <= r_acc_cnt + CNT_W'(1);
      end
    end else if (io_bus.clr_acc) begin
      r_acc     <= '0;
      r_acc_cnt <= '0;
    end
  end

  assign io_bus.in_ready  = ~rst & ~w_full;
  assign io_bus.out_valid = ~w_empty;
  assign io_bus.y         = r_y;
  assign io_bus.parity    = r_parity;
  assign io_bus.acc       = r_acc;
  assign io_bus.acc_cnt   = r_acc_cnt;

endmodule

// File: tb/tb_nor_logic_accum_unit.sv
// Bench for nor_logic_accum_unit: a queue-based model checked every cycle, plus literal checkpoints.
// Two instances share stimulus; the second has a 2-bit counter to exercise saturation.
module tb_nor_logic_accum_unit;

  localparam int DEPTH = 2;

  logic clk;
  logic rst;

  nor_logic_accum_unit_if #(.WIDTH(8), .CNT_W(8)) u_if8 ();
  nor_logic_accum_unit_if #(.WIDTH(8), .CNT_W(2)) u_if2 ();

  assign u_if2.in_valid  = u_if8.in_valid;
  assign u_if2.a         = u_if8.a;
  assign u_if2.b         = u_if8.b;
  assign u_if2.mode      = u_if8.mode;
  assign u_if2.clr_acc   = u_if8.clr_acc;
  assign u_if2.out_ready = u_if8.out_ready;

  nor_logic_accum_unit #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(8)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (u_if8)
  );

  nor_logic_accum_unit #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (u_if2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of {result, parity} entries and a running checksum.
  logic [8:0] q[$];
  logic [7:0] m_acc = 8'h00;
  logic [7:0] m_y   = 8'h00;
  logic       m_par = 1'b0;
  int         m_cnt8 = 0;
  int         m_cnt2 = 0;

  always @(posedge clk or posedge rst) begin
    logic [7:0] res;
    logic [7:0] base;
    bit         take;
    bit         give;
    bit         is_acc;
    if (rst) begin
      q.delete();
      m_acc  = 8'h00;
      m_y    = 8'h00;
      m_par  = 1'b0;
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else begin
      take   = u_if8.in_valid && (q.size() < DEPTH);
      give   = (q.size() > 0) && u_if8.out_ready;
      is_acc = take && (u_if8.mode == 2'b11);
      base   = u_if8.clr_acc ? 8'h00 : m_acc;
      case (u_if8.mode)
        2'b00:   res = u_if8.a ^ u_if8.b;
        2'b01:   res = ~(u_if8.a ^ u_if8.b);
        2'b10:   res = ~(u_if8.a | u_if8.b);
        default: res = base ^ u_if8.a ^ u_if8.b;
      endcase
      if (give) void'(q.pop_front());
      if (take) q.push_back({res, ^res});
      if (is_acc) begin
        m_acc  = res;
        m_cnt8 = u_if8.clr_acc ? 1 : ((m_cnt8 < 255) ? m_cnt8 + 1 : 255);
        m_cnt2 = u_if8.clr_acc ? 1 : ((m_cnt2 < 3) ? m_cnt2 + 1 : 3);
      end else if (u_if8.clr_acc) begin
        m_acc  = 8'h00;
        m_cnt8 = 0;
        m_cnt2 = 0;
      end
      if (q.size() > 0) begin
        m_y   = q[0][8:1];
        m_par = q[0][0];
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready",   32'(u_if8.in_ready),  32'(!rst && (q.size() < DEPTH)));
    check("out_valid",  32'(u_if8.out_valid), 32'(q.size() > 0));
    check("y",          32'(u_if8.y),         32'(m_y));
    check("parity",     32'(u_if8.parity),    32'(m_par));
    check("acc",        32'(u_if8.acc),       32'(m_acc));
    check("acc_cnt",    32'(u_if8.acc_cnt),   32'(m_cnt8));
    check("out_valid2", 32'(u_if2.out_valid), 32'(q.size() > 0));
    check("y2",         32'(u_if2.y),         32'(m_y));
    check("acc_cnt2",   32'(u_if2.acc_cnt),   32'(m_cnt2));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] m, input logic clr);
    u_if8.in_valid = v;
    u_if8.a        = a;
    u_if8.b        = b;
    u_if8.mode     = m;
    u_if8.clr_acc  = clr;
  endtask

  initial begin
    rst = 1'b1;
    u_if8.out_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    tick();
    tick();
    check("rst_out_valid", 32'(u_if8.out_valid), 32'd0);
    check("rst_in_ready",  32'(u_if8.in_ready),  32'd0);
    check("rst_y",         32'(u_if8.y),         32'd0);
    check("rst_acc_cnt",   32'(u_if8.acc_cnt),   32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check("release_in_ready", 32'(u_if8.in_ready), 32'd1);
    tick();

    // Single XOR beat.
    drive(1'b1, 8'hA5, 8'h0F, 2'b00, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    check("xor_valid",  32'(u_if8.out_valid), 32'd1);
    check("xor_y",      32'(u_if8.y),         32'hAA);
    check("xor_parity", 32'(u_if8.parity),    32'd0);
    tick();
    check("xor_drained", 32'(u_if8.out_valid), 32'd0);

    // Mode sweep.
    drive(1'b1, 8'hF0, 8'h3C, 2'b00, 1'b0);
    tick();
    check("sweep_xor", 32'(u_if8.y), 32'hCC);
    drive(1'b1, 8'hF0, 8'h3C, 2'b01, 1'b0);
    tick();
    check("sweep_xnor", 32'(u_if8.y), 32'h33);
    drive(1'b1, 8'hF0, 8'h3C, 2'b10, 1'b0);
    tick();
    check("sweep_nor",    32'(u_if8.y),      32'h03);
    check("sweep_nor_par", 32'(u_if8.parity), 32'd0);

    // Accumulate, then clear together with an ACC beat.
    drive(1'b1, 8'h01, 8'h00, 2'b11, 1'b0);
    tick();
    check("acc1_y", 32'(u_if8.y), 32'h01);
    drive(1'b1, 8'h02, 8'h00, 2'b11, 1'b0);
    tick();
    check("acc2_y", 32'(u_if8.y), 32'h03);
    drive(1'b1, 8'h04, 8'h01, 2'b11, 1'b0);
    tick();
    check("acc3_y",   32'(u_if8.y),       32'h06);
    check("acc3_acc", 32'(u_if8.acc),     32'h06);
    check("acc3_cnt", 32'(u_if8.acc_cnt), 32'd3);
    drive(1'b1, 8'h10, 8'h01, 2'b11, 1'b1);
    tick();
    check("clr_y",   32'(u_if8.y),       32'h11);
    check("clr_acc", 32'(u_if8.acc),     32'h11);
    check("clr_cnt", 32'(u_if8.acc_cnt), 32'd1);
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    tick();

    // Backpressure: fill, hold a third beat, then drain in order.
    u_if8.out_ready = 1'b0;
    drive(1'b1, 8'h01, 8'h00, 2'b00, 1'b0);
    tick();
    drive(1'b1, 8'h02, 8'h00, 2'b00, 1'b0);
    tick();
    check("full_in_ready", 32'(u_if8.in_ready), 32'd0);
    drive(1'b1, 8'h03, 8'h00, 2'b00, 1'b0);
    tick();
    check("held_in_ready", 32'(u_if8.in_ready), 32'd0);
    check("held_head",     32'(u_if8.y),        32'h01);
    u_if8.out_ready = 1'b1;
    tick();
    check("drain1_y", 32'(u_if8.y), 32'h02);
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    check("drain2_y", 32'(u_if8.y), 32'h03);
    tick();
    check("drain_empty", 32'(u_if8.out_valid), 32'd0);
    check("drain_hold_y", 32'(u_if8.y), 32'h03);

    // Counter saturation on the 2-bit instance.
    drive(1'b1, 8'h11, 8'h22, 2'b11, 1'b1);
    tick();
    drive(1'b1, 8'h33, 8'h44, 2'b11, 1'b0);
    tick();
    drive(1'b1, 8'h55, 8'h66, 2'b11, 1'b0);
    tick();
    drive(1'b1, 8'h77, 8'h88, 2'b11, 1'b0);
    tick();
    drive(1'b1, 8'h99, 8'hAA, 2'b11, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    check("sat_cnt2", 32'(u_if2.acc_cnt), 32'd3);
    check("sat_acc2", 32'(u_if2.acc),     32'hBB);
    check("sat_cnt8", 32'(u_if8.acc_cnt), 32'd5);
    tick();

    // Mixed directed traffic with intermittent consumer stalls.
    for (int i = 0; i < 24; i++) begin
      drive(logic'(i % 5 != 4), 8'(i * 37 + 5), 8'(i * 91), 2'(i % 4), logic'(i == 10));
      u_if8.out_ready = logic'(i % 3 != 0);
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    u_if8.out_ready = 1'b1;
    repeat (3) tick();

    // Asynchronous reset with two entries queued.
    u_if8.out_ready = 1'b0;
    drive(1'b1, 8'h5A, 8'h00, 2'b11, 1'b1);
    tick();
    drive(1'b1, 8'h01, 8'h02, 2'b00, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    check("pre_rst_acc",   32'(u_if8.acc),       32'h5A);
    check("pre_rst_valid", 32'(u_if8.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_out_valid", 32'(u_if8.out_valid), 32'd0);
    check("async_acc",       32'(u_if8.acc),       32'd0);
    check("async_acc_cnt",   32'(u_if8.acc_cnt),   32'd0);
    check("async_in_ready",  32'(u_if8.in_ready),  32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check("post_rst_in_ready", 32'(u_if8.in_ready), 32'd1);
    u_if8.out_ready = 1'b1;
    drive(1'b1, 8'h0F, 8'hF0, 2'b10, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    check("post_rst_y", 32'(u_if8.y), 32'h00);
    check("post_rst_valid", 32'(u_if8.out_valid), 32'd1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nor_logic_accum_unit.md
Name: nor_logic_accum_unit

Overview:
- Parametrised successor to the team's single-bit NOR-built XOR cell.
- Bitwise XOR, XNOR and NOR over WIDTH-bit operands, plus an accumulate mode that XOR-folds a running checksum (partial-product check path for the Vedic multiplier datapath).
- Results carry an even-parity bit and are buffered in a DEPTH-entry output FIFO under valid/ready handshake on both sides.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
DEPTH, 2, output FIFO entries; power of two, >=2
CNT_W, 8, width of accumulate-event counter (saturating)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat
a  input  WIDTH  operand A
b  input  WIDTH  operand B
mode  input  2  00 XOR, 01 XNOR, 10 NOR, 11 ACC
clr_acc  input  1  clear accumulator and counter (single-cycle strobe)
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer takes head
y  output  WIDTH  FIFO head result
parity  output  1  XOR-reduction of y at the FIFO head (even parity)
acc  output  WIDTH  current accumulator value
acc_cnt  output  CNT_W  accepted ACC beats since last clear, saturating

Behaviour:
- One clock; reset is asynchronous and active-high. While rst=1: FIFO empty, out_valid=0, in_ready=0, y=0, parity=0, acc=0, acc_cnt=0. First cycle after release: in_ready=1.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = !full. No bypass: a full FIFO accepts nothing even when popping that cycle.
- Result computed combinationally at accept:
  - XOR: a^b
  - XNOR: ~(a^b)
  - NOR: ~(a|b)
  - ACC: acc^a^b, i.e. the new accumulator value.
- Pushed entry is {result, ^result}.
- Latency: result accepted at edge N is visible at the head (out_valid=1) after edge N when the FIFO was empty. Otherwise it becomes visible in order behind earlier entries. Strict FIFO order.
- Simultaneous push and pop while not full and not empty: occupancy unchanged, head advances.
- Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- y and parity hold their last value while out_valid=0. They change only on pop or push-to-empty.
- Accumulator update occurs only on accept with mode=11: acc <= acc^a^b; acc_cnt <= acc_cnt+1, saturating at 2^CNT_W-1.
- clr_acc without an ACC accept: acc<=0, acc_cnt<=0.
- clr_acc together with an ACC accept: clear takes priority for the old value. acc <= a^b, acc_cnt <= 1, and the pushed result is a^b.
- clr_acc never affects FIFO contents.
- mode, a and b are sampled only on accept; values are don't-care otherwise.
- Reset mid-operation: all FIFO entries discarded, accumulator and counter cleared immediately (asynchronous).

Test Plan:
- Reset then one XOR beat, a=8'hA5, b=8'h0F, consumer ready -> after 1 edge out_valid=1, y=8'hAA, parity=0; next edge out_valid=0.
- Mode sweep a=8'hF0, b=8'h3C with out_ready=1 -> XOR 8'hCC, XNOR 8'h33, NOR 8'h03 (parity 0), all in order.
- ACC beats (01,00), (02,00), (04,01) -> results 01, 03, 06; acc=8'h06, acc_cnt=3. Then clr_acc with ACC beat (10,01) -> y=8'h11, acc=8'h11, acc_cnt=1.
- out_ready=0, push XOR beats until in_ready=0 -> exactly DEPTH=2 entries accepted, third held. Raise out_ready -> drains in order, then third accepted, nothing lost or duplicated.
- CNT_W=2: issue 5 ACC beats -> acc_cnt saturates at 3; acc still equals XOR of all 10 operands.
- Assert rst with 2 entries queued and acc=8'h5A -> out_valid, acc and acc_cnt go to 0 without a clock edge. After release, in_ready=1 on the first cycle.
